// File: rtl/me_stream_feeder.sv
// me_stream_feeder: streams a current block and a dual-ported search window into a PE row, then hands back the PE result; optional WAIT_DONE timeout under ME_FEEDER_TIMEOUT_EN
`ifndef BLK_SIZE
`define BLK_SIZE 8
`endif
module me_stream_feeder #(
  parameter int BLK_SIZE = `BLK_SIZE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  output logic       busy,
  output logic [7:0] cur_addr,
  input  logic [7:0] cur_data,
  output logic [9:0] win_addr_p,
  output logic [9:0] win_addr_pp,
  input  logic [7:0] win_data_p,
  input  logic [7:0] win_data_pp,
  output logic       pe_reset,
  output logic       pe_start,
  output logic [7:0] pe_c,
  output logic [7:0] pe_p,
  output logic [7:0] pe_p_prime,
  input  logic       pe_done,
  input  logic [7:0] pe_mme,
  input  logic [7:0] pe_m_i,
  input  logic [7:0] pe_m_j,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_mv_i,
  output logic [7:0] res_mv_j,
  output logic [7:0] res_sad,
  output logic       res_err
);
  localparam int N  = BLK_SIZE;
  localparam int N2 = N * N;
  localparam int N3 = N2 * N;
  localparam int KW = $clog2(N3);
  typedef enum logic [2:0] {IDLE, CLR, STREAM, DRAIN, WAIT_DONE, RESULT} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic vld_q, vld_d, start_q, start_d;
  logic [7:0] mi_q, mi_d, mj_q, mj_d, sad_q, sad_d;
  logic timeout, cap, err_w;
  logic [31:0] kx, ij;
`ifdef ME_FEEDER_TIMEOUT_EN
  logic [15:0] to_q, to_d;
  logic err_q, err_d;
  // watchdog counts only while waiting for the PE row; an error result is forced at the limit
  always_comb begin
    to_d = (state_q == WAIT_DONE) ? to_q + 16'd1 : 16'd0;
    err_d = cap ? !pe_done : err_q;
  end
  // watchdog and error flag registers
  always_ff @(posedge clk) begin
    to_q <= reset ? 16'd0 : to_d;
    err_q <= reset ? 1'b0 : err_d;
  end
  assign timeout = (to_q == 16'(4 * N3 - 1));
  assign err_w = err_q;
`else
  assign timeout = 1'b0;
  assign err_w = 1'b0;
`endif
  assign cap = (state_q == WAIT_DONE) && (pe_done || timeout);
  // state register
  always_ff @(posedge clk) begin
    state_q <= reset ? IDLE : state_d;
  end
  // next-state logic; go is only looked at in IDLE and pe_done only in WAIT_DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      state_d = go ? CLR : IDLE;
      CLR:       state_d = STREAM;
      STREAM:    state_d = (k_q == KW'(N3 - 1)) ? DRAIN : STREAM;
      DRAIN:     state_d = WAIT_DONE;
      WAIT_DONE: state_d = (pe_done || timeout) ? RESULT : WAIT_DONE;
      RESULT:    state_d = res_ready ? IDLE : RESULT;
      default:   state_d = IDLE;
    endcase
  end
  // stream counter, data-valid/start tags delayed to line up with memory latency, and result capture
  always_comb begin
    k_d = (state_q == STREAM) ? k_q + 1'b1 : '0;
    vld_d = (state_q == STREAM);
    start_d = (state_q == STREAM) && (k_q == '0);
    mi_d = cap ? (pe_done ? pe_m_i : 8'd0) : mi_q;
    mj_d = cap ? (pe_done ? pe_m_j : 8'd0) : mj_q;
    sad_d = cap ? (pe_done ? pe_mme : 8'd0) : sad_q;
  end
  // datapath registers
  always_ff @(posedge clk) begin
    k_q <= reset ? '0 : k_d;
    vld_q <= reset ? 1'b0 : vld_d;
    start_q <= reset ? 1'b0 : start_d;
    mi_q <= reset ? 8'd0 : mi_d;
    mj_q <= reset ? 8'd0 : mj_d;
    sad_q <= reset ? 8'd0 : sad_d;
  end
  // outputs: addresses from k while streaming, PE data gated to the cycles carrying valid reads
  always_comb begin
    kx = 32'(k_q);
    ij = kx / 32'(N2) + (kx % 32'(N2)) / 32'(N);
    busy = (state_q != IDLE);
    pe_reset = (state_q == CLR);
    pe_start = start_q;
    cur_addr = (state_q == STREAM) ? 8'(kx % 32'(N2)) : 8'd0;
    win_addr_pp = (state_q == STREAM) ? 10'(ij * 32'(2 * N) + kx % 32'(N)) : 10'd0;
    win_addr_p = (state_q == STREAM) ? 10'(ij * 32'(2 * N) + 32'(N) + kx % 32'(N)) : 10'd0;
    pe_c = vld_q ? cur_data : 8'd0;
    pe_p = vld_q ? win_data_p : 8'd0;
    pe_p_prime = vld_q ? win_data_pp : 8'd0;
    res_valid = (state_q == RESULT);
    res_mv_i = mi_q;
    res_mv_j = mj_q;
    res_sad = sad_q;
    res_err = err_w;
  end
endmodule
